// File: rtl/reg_file_param_pkg.sv
// regfile_pkg: shared defaults, scrub FSM encoding and address-range helper.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_e;

    // True when addr names a real, writable/readable register.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned num_regs,
                                     input logic zero_r0);
        return (addr < num_regs) && !(zero_r0 && addr == 0);
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: write, read, scoreboard and scrub signals of the register file.
interface reg_file_param_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 4
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic              rd_a_pend;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              rd_b_pend;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              scrub_req;
    logic              scrub_busy;
    logic              scrub_done;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, sb_set, sb_addr, scrub_req,
        input  rd_a_data, rd_a_pend, rd_b_data, rd_b_pend, scrub_busy, scrub_done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr, sb_set, sb_addr, scrub_req,
        output rd_a_data, rd_a_pend, rd_b_data, rd_b_pend, scrub_busy, scrub_done, wr_err
    );

endinterface

// File: rtl/reg_file_param_scrub_fsm.sv
// regfile_scrub_fsm: walks the file one register per cycle, zeroing it.
module regfile_scrub_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              scrub_req_i,
    input  logic              wr_en_i,
    input  logic              sb_set_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              scrub_we_o,
    output logic [ADDR_W-1:0] scrub_idx_o
);

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last;

    assign last = idx_q == ADDR_W'(NUM_REGS - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            state_d = scrub_req_i ? SCRUB : IDLE;
            idx_d   = '0;
        end else begin
            err_d   = wr_en_i || sb_set_i;
            state_d = last ? IDLE : SCRUB;
            idx_d   = last ? '0 : idx_q + ADDR_W'(1);
            done_d  = last;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = state_q == SCRUB;
    assign scrub_we_o  = state_q == SCRUB;
    assign scrub_idx_o = idx_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two registered read ports,
// optional write bypass and hardwired R0, pending scoreboard and scrub sequencer.
module reg_file_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = 4,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1
) (
    input logic             clk,
    input logic             clr,
    reg_file_param_if.slave bus
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic              pend_q [NUM_REGS];
    logic              pend_d [NUM_REGS];
    logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic              pa_q, pa_d, pb_q, pb_d;
    logic              busy, scrub_we;
    logic [ADDR_W-1:0] scrub_idx;
    logic              wr_ok, sb_ok, a_ok, b_ok, a_hit, b_hit;

    regfile_scrub_fsm #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_scrub (
        .clk        (clk),
        .clr        (clr),
        .scrub_req_i(bus.scrub_req),
        .wr_en_i    (bus.wr_en),
        .sb_set_i   (bus.sb_set),
        .busy_o     (busy),
        .done_o     (bus.scrub_done),
        .err_o      (bus.wr_err),
        .scrub_we_o (scrub_we),
        .scrub_idx_o(scrub_idx)
    );

    assign wr_ok = bus.wr_en && !busy && addr_ok(32'(bus.wr_addr), NUM_REGS, ZERO_R0 != 0);
    assign sb_ok = bus.sb_set && !busy && addr_ok(32'(bus.sb_addr), NUM_REGS, ZERO_R0 != 0);
    assign a_ok  = addr_ok(32'(bus.rd_a_addr), NUM_REGS, ZERO_R0 != 0);
    assign b_ok  = addr_ok(32'(bus.rd_b_addr), NUM_REGS, ZERO_R0 != 0);

    // Scrub and accepted writes never coincide; a set beats a same-cycle write clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (scrub_we) begin
            mem_d[scrub_idx]  = '0;
            pend_d[scrub_idx] = 1'b0;
        end
        if (wr_ok) begin
            mem_d[bus.wr_addr]  = bus.wr_data;
            pend_d[bus.wr_addr] = 1'b0;
        end
        if (sb_ok) pend_d[bus.sb_addr] = 1'b1;
    end

    // Without bypass a same-cycle write is hidden; scrub effects always show.
    assign a_hit  = BYPASS == 0 && wr_ok && bus.rd_a_addr == bus.wr_addr;
    assign b_hit  = BYPASS == 0 && wr_ok && bus.rd_b_addr == bus.wr_addr;
    assign rd_a_d = !a_ok ? '0 : a_hit ? mem_q[bus.rd_a_addr] : mem_d[bus.rd_a_addr];
    assign rd_b_d = !b_ok ? '0 : b_hit ? mem_q[bus.rd_b_addr] : mem_d[bus.rd_b_addr];
    assign pa_d   = a_ok && pend_d[bus.rd_a_addr];
    assign pb_d   = b_ok && pend_d[bus.rd_b_addr];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_q  <= '{default: '0};
            pend_q <= '{default: 1'b0};
            rd_a_q <= '0;
            rd_b_q <= '0;
            pa_q   <= 1'b0;
            pb_q   <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            pa_q   <= pa_d;
            pb_q   <= pb_d;
        end
    end

    assign bus.rd_a_data  = rd_a_q;
    assign bus.rd_b_data  = rd_b_q;
    assign bus.rd_a_pend  = pa_q;
    assign bus.rd_b_pend  = pb_q;
    assign bus.scrub_busy = busy;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: scoreboard bench driving a bypass/plain-R0 instance and a no-bypass/zero-R0 instance
module tb_reg_file_param;
  localparam int AD = 0, AP = 1, BD = 2, BP = 3, BSY = 4, DN = 5, ER = 6;
  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;
  logic        clk = 1'b0;
  logic        clr;
  logic        wr_en, sb_set, scrub_req;
  logic [3:0]  wr_addr, rd_a_addr, rd_b_addr, sb_addr;
  logic [31:0] wr_data;
  logic [31:0] obs [2][7];
  exp_t        sbq[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n, m, k;
  reg_file_param_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
  reg_file_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) u0 (
    .clk(clk), .clr(clr), .bus(bus0)
  );
  reg_file_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(0)) u1 (
    .clk(clk), .clr(clr), .bus(bus1)
  );
  assign bus0.wr_en = wr_en;         assign bus1.wr_en = wr_en;
  assign bus0.wr_addr = wr_addr;     assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;     assign bus1.wr_data = wr_data;
  assign bus0.rd_a_addr = rd_a_addr; assign bus1.rd_a_addr = rd_a_addr;
  assign bus0.rd_b_addr = rd_b_addr; assign bus1.rd_b_addr = rd_b_addr;
  assign bus0.sb_set = sb_set;       assign bus1.sb_set = sb_set;
  assign bus0.sb_addr = sb_addr;     assign bus1.sb_addr = sb_addr;
  assign bus0.scrub_req = scrub_req; assign bus1.scrub_req = scrub_req;
  always_comb begin
    obs[0][AD]  = bus0.rd_a_data;
    obs[0][AP]  = {31'b0, bus0.rd_a_pend};
    obs[0][BD]  = bus0.rd_b_data;
    obs[0][BP]  = {31'b0, bus0.rd_b_pend};
    obs[0][BSY] = {31'b0, bus0.scrub_busy};
    obs[0][DN]  = {31'b0, bus0.scrub_done};
    obs[0][ER]  = {31'b0, bus0.wr_err};
    obs[1][AD]  = bus1.rd_a_data;
    obs[1][AP]  = {31'b0, bus1.rd_a_pend};
    obs[1][BD]  = bus1.rd_b_data;
    obs[1][BP]  = {31'b0, bus1.rd_b_pend};
    obs[1][BSY] = {31'b0, bus1.scrub_busy};
    obs[1][DN]  = {31'b0, bus1.scrub_done};
    obs[1][ER]  = {31'b0, bus1.wr_err};
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        n_cmp++;
        if (obs[sbq[i].dut][sbq[i].fld] !== sbq[i].val) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", sbq[i].name,
                   sbq[i].dut, cyc, obs[sbq[i].dut][sbq[i].fld], sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end
  function automatic logic [31:0] fv(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction
  task automatic ex(int d, int dut, int f, logic [31:0] v, string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.dut  = dut;
    e.fld  = f;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask
  task automatic ex2(int d, int f, logic [31:0] v, string nm);
    ex(d, 0, f, v, nm);
    ex(d, 1, f, v, nm);
  endtask
  task automatic nx();
    @(negedge clk);
    wr_en     = 1'b0;
    sb_set    = 1'b0;
    scrub_req = 1'b0;
  endtask
  task automatic wr(int a, logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
  endtask
  initial begin
    clr = 1'b0;
    wr_en = 1'b0; sb_set = 1'b0; scrub_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_a_addr = '0; rd_b_addr = '0; sb_addr = '0;
    @(negedge clk);
    n_cmp++;
    if (bus0.rd_a_data !== 32'h0 || bus1.rd_a_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct rst rd_a_data: %h %h", bus0.rd_a_data, bus1.rd_a_data);
    end
    n_cmp++;
    if (bus0.rd_b_data !== 32'h0 || bus1.rd_b_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct rst rd_b_data: %h %h", bus0.rd_b_data, bus1.rd_b_data);
    end
    n_cmp++;
    if (bus0.scrub_busy !== 1'b0 || bus1.scrub_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL direct rst scrub_busy");
    end
    n_cmp++;
    if (bus0.rd_a_pend !== 1'b0 || bus1.rd_b_pend !== 1'b0) begin
      n_bad++;
      $display("FAIL direct rst pend");
    end
    ex2(1, AD, 0, "rst_rd_a"); ex2(1, AP, 0, "rst_pend_a"); ex2(1, BD, 0, "rst_rd_b");
    ex2(1, BSY, 0, "rst_busy"); ex2(1, DN, 0, "rst_done"); ex2(1, ER, 0, "rst_err");
    nx(); clr = 1'b1;
    nx(); wr(5, 32'hDEAD_BEEF); rd_b_addr = 4'd6;
    nx(); rd_a_addr = 4'd5;
    ex2(1, AD, 32'hDEAD_BEEF, "wr_rd_r5"); ex2(1, BD, 0, "rd_b_r6");
    nx(); wr(3, 32'h1234_5678); rd_a_addr = 4'd3;
    ex(1, 0, AD, 32'h1234_5678, "bypass_r3"); ex(1, 1, AD, 0, "nobypass_r3");
    nx(); ex2(1, AD, 32'h1234_5678, "r3_settled");
    nx(); wr(0, 32'hFFFF_FFFF); sb_set = 1'b1; sb_addr = 4'd0; rd_a_addr = 4'd0;
    ex(1, 0, AD, 32'hFFFF_FFFF, "r0_plain"); ex(1, 0, AP, 1, "r0_plain_pend");
    ex(1, 1, AD, 0, "r0_zero"); ex(1, 1, AP, 0, "r0_zero_pend");
    nx(); ex(1, 0, AD, 32'hFFFF_FFFF, "r0_plain_hold"); ex(1, 1, AD, 0, "r0_zero_hold");
    ex(1, 1, AP, 0, "r0_zero_pend_hold");
    nx(); sb_set = 1'b1; sb_addr = 4'd7; rd_a_addr = 4'd7; rd_b_addr = 4'd7;
    ex2(1, AP, 1, "sb_r7_a"); ex2(1, BP, 1, "sb_r7_b");
    nx(); sb_set = 1'b1; sb_addr = 4'd7; wr(7, 32'hA5A5_A5A5);
    ex2(1, AP, 1, "set_wins"); ex(1, 0, AD, 32'hA5A5_A5A5, "r7_byp"); ex(1, 1, AD, 0, "r7_old");
    nx(); wr(7, 32'h5A5A_5A5A);
    ex2(1, AP, 0, "wr_clears"); ex2(1, BP, 0, "wr_clears_b");
    ex(1, 0, AD, 32'h5A5A_5A5A, "r7_byp2"); ex(1, 1, AD, 32'hA5A5_A5A5, "r7_old2");
    for (int i = 0; i < 16; i++) begin
      nx(); wr(i, fv(i)); rd_a_addr = 4'(i); rd_b_addr = 4'd9;
      ex(1, 0, AD, fv(i), "fill_byp");
      if (i == 0) ex(1, 1, AD, 0, "fill_r0_zero");
      if (i == 12) begin
        sb_set = 1'b1; sb_addr = 4'd9;
        ex2(1, BP, 1, "pend_r9");
      end
    end
    nx(); scrub_req = 1'b1; rd_a_addr = 4'd15; rd_b_addr = 4'd0; n = cyc;
    ex2(1, BSY, 1, "busy_rise"); ex2(16, BSY, 1, "busy_last"); ex2(17, BSY, 0, "busy_fall");
    ex2(16, DN, 0, "done_early"); ex2(17, DN, 1, "done_pulse"); ex2(18, DN, 0, "done_once");
    ex2(4, ER, 0, "err_quiet"); ex2(5, ER, 1, "err_wr"); ex2(6, ER, 0, "err_single");
    ex2(10, ER, 1, "err_sb"); ex2(11, ER, 0, "err_sb_single");
    ex2(1, AD, fv(15), "pre_scrub_r15"); ex2(5, AD, fv(15), "live_unscrubbed");
    ex2(16, AD, fv(15), "r15_before_last"); ex2(17, AD, 0, "r15_scrubbed");
    ex(1, 0, BD, fv(0), "pre_scrub_r0"); ex(2, 0, BD, 0, "r0_scrubbed");
    for (int i = 1; i <= 17; i++) begin
      nx();
      if (i == 4) wr(2, 32'hFFFF_FFFF);
      if (i == 6) scrub_req = 1'b1;
      if (i == 9) begin sb_set = 1'b1; sb_addr = 4'd2; end
    end
    for (int i = 0; i < 16; i++) begin
      nx(); rd_a_addr = 4'(i); rd_b_addr = 4'(15 - i);
      ex2(1, AD, 0, "scrub_zero_a"); ex2(1, AP, 0, "scrub_pend_a");
      ex2(1, BD, 0, "scrub_zero_b"); ex2(1, BP, 0, "scrub_pend_b");
    end
    nx(); wr(15, 32'h0F0F_0F0F); rd_a_addr = 4'd15;
    nx(); scrub_req = 1'b1; m = cyc;
    ex2(1, AD, 32'h0F0F_0F0F, "r15_pre"); ex2(8, BSY, 1, "busy_mid");
    ex2(8, AD, 32'h0F0F_0F0F, "r15_mid");
    repeat (8) nx();
    #2 clr = 1'b0;
    #1;
    n_cmp++;
    if (bus0.scrub_busy !== 1'b0 || bus1.scrub_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL direct async reset scrub_busy");
    end
    n_cmp++;
    if (bus0.rd_a_data !== 32'h0 || bus1.rd_a_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct async reset rd_a_data: %h %h", bus0.rd_a_data, bus1.rd_a_data);
    end
    n_cmp++;
    if (bus0.scrub_done !== 1'b0 || bus1.scrub_done !== 1'b0) begin
      n_bad++;
      $display("FAIL direct async reset scrub_done");
    end
    ex2(1, BSY, 0, "rst_mid_busy"); ex2(1, AD, 0, "rst_mid_data"); ex2(1, DN, 0, "rst_mid_done");
    nx();
    for (int j = 1; j <= 12; j++) ex2(j, DN, 0, "no_done_after_rst");
    ex2(2, AD, 0, "r15_cleared"); ex2(3, BSY, 0, "idle_after_rst");
    nx(); clr = 1'b1;
    nx(); wr(4, 32'hCAFE_F00D); rd_a_addr = 4'd4;
    ex(1, 0, AD, 32'hCAFE_F00D, "post_rst_byp"); ex(1, 1, AD, 0, "post_rst_old");
    nx(); ex2(1, AD, 32'hCAFE_F00D, "post_rst_rd");
    repeat (10) nx();
    nx(); scrub_req = 1'b1; k = cyc;
    ex2(17, DN, 1, "done_a"); ex2(18, BSY, 1, "restart_busy"); ex2(33, BSY, 1, "restart_last");
    ex2(34, BSY, 0, "restart_fall"); ex2(34, DN, 1, "done_b"); ex2(35, DN, 0, "done_b_once");
    repeat (17) nx();
    scrub_req = 1'b1;
    repeat (20) nx();
    #2;
    foreach (sbq[i]) begin
      n_bad++;
      $display("FAIL %s dut%0d: never compared, expected %h at cyc %0d", sbq[i].name,
               sbq[i].dut, sbq[i].val, sbq[i].cyc);
    end
    if (n_bad == n_cmp) $display("FAIL every comparison mismatched");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $display(n_bad == 0 ? "PASS" : "FAIL");
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised general-purpose register file that replaces the fixed 16 x 32-bit register bank.
- Ports: one write port, two registered read ports with optional write-to-read bypass, and an optional hardwired-zero R0.
- Per-register pending scoreboard for the control unit.
- Hardware scrub sequencer that zeroes the file one register per cycle.

Parameters:
DATA_W, 32, width of each register in bits
NUM_REGS, 16, number of registers (2..64)
ADDR_W, 4, register address width; must be at least clog2(NUM_REGS)
ZERO_R0, 0, 1 = R0 always reads 0, ignores writes, and is never pending
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data
rd_a_addr  input  ADDR_W  read port A index
rd_a_data  output  DATA_W  read port A data, 1-cycle latency
rd_a_pend  output  1  pending bit of the register addressed on port A, 1-cycle latency
rd_b_addr  input  ADDR_W  read port B index
rd_b_data  output  DATA_W  read port B data, 1-cycle latency
rd_b_pend  output  1  pending bit of the register addressed on port B, 1-cycle latency
sb_set  input  1  mark register sb_addr pending (a result is in flight)
sb_addr  input  ADDR_W  scoreboard set index
scrub_req  input  1  start zeroing sequence
scrub_busy  output  1  high while a scrub is in progress
scrub_done  output  1  one-cycle pulse after the last register is scrubbed
wr_err  output  1  one-cycle pulse: a wr_en or sb_set was dropped during a scrub

Behaviour:
Reset (clr=0, asynchronous):
- All storage, pending bits and outputs go to 0.
- FSM goes to IDLE; scrub index goes to 0.

Writes:
- Accepted when wr_en=1, scrub_busy=0 and wr_addr<NUM_REGS.
- Ignored when ZERO_R0=1 and wr_addr=0.
- An accepted write updates storage at the rising edge.

Reads (both ports identical and independent):
- At each edge, rd_x_data <= post-edge value of register rd_x_addr.
- When BYPASS=1 and an accepted write targets the same index, rd_x_data returns wr_data.
- When BYPASS=0, rd_x_data returns the old value.
- An address at or above NUM_REGS, or R0 with ZERO_R0=1, returns 0.

Scoreboard:
- pend[i] is set by sb_set and cleared by an accepted write to i.
- Simultaneous set and write to the same index: set wins.
- sb_set is ignored for an out-of-range index or for R0 with ZERO_R0=1.
- rd_x_pend <= post-edge pend[rd_x_addr], registered together with rd_x_data.
- With BYPASS=0, rd_x_pend still reflects the post-edge value.

Scrub FSM (states IDLE, SCRUB):
- IDLE -> SCRUB: on scrub_req=1; idx <= 0 and scrub_busy <= 1.
- Each SCRUB cycle: storage[idx] <= 0, pend[idx] <= 0, idx <= idx+1.
- SCRUB -> IDLE: on the edge that scrubs idx = NUM_REGS-1. scrub_busy falls at that edge, and scrub_done pulses high for exactly the following cycle.
- Total scrub_busy duration is NUM_REGS cycles.
- scrub_req while busy is ignored.
- scrub_req in the same cycle as the scrub_done pulse starts a new scrub.
- While scrub_busy=1, wr_en or sb_set is dropped, and wr_err pulses 1 the next cycle. wr_err is a single pulse per offending cycle.
- Reads stay live during a scrub and return current contents: scrubbed entries read 0, unscrubbed entries read their old values.
- Reset mid-scrub aborts immediately. Everything returns to 0 and no scrub_done pulse is produced.

Decomposition:
Shared package regfile_pkg:
- Default DATA_W and NUM_REGS.
- Scrub FSM state encoding: IDLE=1'b0, SCRUB=1'b1.
- Helper function for the address-range check.

One sub-module, regfile_scrub_fsm:
- Contains the state register, index counter, and busy/done/err generation.
- Drives the scrub write index and enable into the storage array.
- Storage, bypass and scoreboard logic stay in reg_file_param.

Test Plan:
- Write/read back: reset; write R5=0xDEADBEEF, then set rd_a_addr=5 the next cycle -> rd_a_data=0xDEADBEEF one cycle later; rd_b reading R6 -> 0.
- Bypass: in one cycle, wr_en R3=0x12345678 and rd_a_addr=3 -> next cycle rd_a_data=0x12345678 with BYPASS=1, or the previous value 0 with BYPASS=0.
- Zero register (ZERO_R0=1): write R0=0xFFFFFFFF, then read R0 -> 0; sb_set R0 -> rd_a_pend=0.
- Scoreboard:
  - sb_set R7, then read R7 -> rd_a_pend=1.
  - sb_set R7 plus a write to R7 in the same cycle -> pend stays 1.
  - A later write to R7 alone -> pend=0.
- Scrub:
  - Fill R0..R15 with nonzero values, then pulse scrub_req -> scrub_busy high for 16 cycles, then scrub_done high for 1 cycle.
  - All registers then read 0 and all pend bits are 0.
  - A wr_en at cycle 4 of the scrub is dropped and wr_err pulses.
- Reset mid-scrub: drop clr at cycle 8 of the scrub -> outputs 0 immediately, no scrub_done pulse, and a normal write/read works after clr returns high.
